// File: rtl/mul_csv_sgn_arbiter.sv
// Round-robin arbiter sharing one signed carry-save multiplier among numReq requesters; 1-cycle registered result.
// Optional MUL_CSV_ARB_FINAL_ADD_EN adds a registered resolved product out_p_o; backpressure blocks all grants.
module mul_csv_sgn_arbiter #(
    parameter int numReq = 4,
    parameter int widthX = 8,
    parameter int widthY = 8,
    parameter int speed  = 1,
    parameter int cntW   = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [numReq-1:0]                 req_valid_i,
    output logic [numReq-1:0]                 req_ready_o,
    input  logic [numReq*widthX-1:0]          req_xs_i,
    input  logic [numReq*widthX-1:0]          req_xc_i,
    input  logic [numReq*widthY-1:0]          req_y_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [widthX+widthY-1:0]          out_ps_o,
    output logic [widthX+widthY-1:0]          out_pc_o,
    output logic [$clog2(numReq)-1:0]         out_id_o,
    output logic [cntW-1:0]                   op_count_o
`ifdef MUL_CSV_ARB_FINAL_ADD_EN
    ,
    output logic [widthX+widthY-1:0]          out_p_o
`endif
);
    localparam int idW = $clog2(numReq);
    localparam int wP  = widthX + widthY;

    logic [idW-1:0]    rr_q, rr_d, gnt, cand;
    logic              found, slot_free, fire;
    logic              out_valid_q;
    logic [wP-1:0]     ps_q, pc_q;
    logic [idW-1:0]    id_q;
    logic [cntW-1:0]   cnt_q, cnt_d;

    // First valid requester at or after rr_q, wrapping; gnt falls back to rr_q for the operand mux.
    always_comb begin
        found = 1'b0;
        gnt   = rr_q;
        cand  = '0;
        for (int i = 0; i < numReq; i++) begin
            cand = idW'((32'(rr_q) + 32'(i)) % 32'(numReq));
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    assign slot_free = !out_valid_q || out_ready_i;
    assign fire      = slot_free && found;

    always_comb begin
        req_ready_o = '0;
        for (int r = 0; r < numReq; r++) begin
            req_ready_o[r] = fire && (gnt == idW'(r));
        end
    end

    logic [widthX-1:0] xs_sel, xc_sel;
    logic [widthY-1:0] y_sel;
    logic [wP-1:0]     xs_ext, xc_ext, y_ext, pp_s, pp_c;

    assign xs_sel = req_xs_i[gnt*widthX +: widthX];
    assign xc_sel = req_xc_i[gnt*widthX +: widthX];
    assign y_sel  = req_y_i[gnt*widthY +: widthY];

    assign xs_ext = {{widthY{xs_sel[widthX-1]}}, xs_sel};
    assign xc_ext = {{widthY{xc_sel[widthX-1]}}, xc_sel};
    assign y_ext  = {{widthX{y_sel[widthY-1]}}, y_sel};

    // Fast tree keeps XS*Y and XC*Y as separate carry-save halves; slow tree pre-adds the multiplier.
    generate
        if (speed != 0) begin : g_fast
            assign pp_s = xs_ext * y_ext;
            assign pp_c = xc_ext * y_ext;
        end else begin : g_small
            assign pp_s = (xs_ext + xc_ext) * y_ext;
            assign pp_c = '0;
        end
    endgenerate

    assign rr_d  = (gnt == idW'(numReq - 1)) ? '0 : gnt + 1'b1;
    assign cnt_d = (cnt_q == {cntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            ps_q        <= '0;
            pc_q        <= '0;
            id_q        <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
        end else if (fire) begin
            out_valid_q <= 1'b1;
            ps_q        <= pp_s;
            pc_q        <= pp_c;
            id_q        <= gnt;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_ps_o    = ps_q;
    assign out_pc_o    = pc_q;
    assign out_id_o    = id_q;
    assign op_count_o  = cnt_q;

`ifdef MUL_CSV_ARB_FINAL_ADD_EN
    logic [wP-1:0] p_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_q <= '0;
        end else if (fire) begin
            p_q <= pp_s + pp_c;
        end
    end

    assign out_p_o = p_q;
`else
    // Carry-save result only; the downstream adder resolves PS+PC.
`endif
endmodule

// File: tb/tb_mul_csv_sgn_arbiter.sv
// Directed vector table plus hand sequences for round-robin, backpressure, async reset and counter saturation.
module tb_mul_csv_sgn_arbiter;
    localparam int NR = 4;
    localparam int WX = 8;
    localparam int WY = 8;
    localparam int CW = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [NR-1:0]     req_valid_i = '0;
    logic [NR-1:0]     req_ready_o;
    logic [NR*WX-1:0]  req_xs_i = '0;
    logic [NR*WX-1:0]  req_xc_i = '0;
    logic [NR*WY-1:0]  req_y_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [WX+WY-1:0]  out_ps_o, out_pc_o;
    logic [1:0]        out_id_o;
    logic [CW-1:0]     op_count_o;
`ifdef MUL_CSV_ARB_FINAL_ADD_EN
    logic [WX+WY-1:0]  out_p_o;
`endif

    mul_csv_sgn_arbiter #(.numReq(NR), .widthX(WX), .widthY(WY), .speed(1), .cntW(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_xs_i(req_xs_i), .req_xc_i(req_xc_i), .req_y_i(req_y_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_ps_o(out_ps_o), .out_pc_o(out_pc_o), .out_id_o(out_id_o),
        .op_count_o(op_count_o)
`ifdef MUL_CSV_ARB_FINAL_ADD_EN
        , .out_p_o(out_p_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  vld;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [1:0]  id;
        logic [15:0] sum;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[14];
    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] psum();
        return out_ps_o + out_pc_o;
    endfunction

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        #2 rst_i = 1'b0;
    endtask

    logic [1:0] fair_ids[6];

    initial begin
        // r0: 5*5=25, r1: 5*-4=-20, r2: -6*10=-60, r3: 50*7=350
        req_xs_i = {8'h64, 8'hF9, 8'h03, 8'h03};
        req_xc_i = {8'hCE, 8'h01, 8'h02, 8'h02};
        req_y_i  = {8'h07, 8'h0A, 8'hFC, 8'h05};

        tbl[0]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 16'hFFEC, 4'd1};
        tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 16'hFFEC, 4'd1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hFFC4, 4'd2};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h015E, 4'd3};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h0019, 4'd4};
        tbl[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 16'h0019, 4'd4};
        tbl[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 16'h0019, 4'd4};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'hFFEC, 4'd5};
        tbl[8]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hFFC4, 4'd6};
        tbl[9]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h0019, 4'd7};
        tbl[10] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h015E, 4'd8};
        tbl[11] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, 16'h015E, 4'd8};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 16'h015E, 4'd8};
        tbl[13] = '{4'b0110, 1'b0, 4'b0010, 1'b1, 2'd1, 16'hFFEC, 4'd9};

        fair_ids[0] = 2'd0; fair_ids[1] = 2'd1; fair_ids[2] = 2'd2;
        fair_ids[3] = 2'd3; fair_ids[4] = 2'd0; fair_ids[5] = 2'd1;

        #1 rst_i = 1'b1;
        #2;
        chk("reset_valid", 32'(out_valid_o), 32'd0);
        chk("reset_ps",    32'(out_ps_o),    32'd0);
        chk("reset_pc",    32'(out_pc_o),    32'd0);
        chk("reset_id",    32'(out_id_o),    32'd0);
        chk("reset_cnt",   32'(op_count_o),  32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #2 rst_i = 1'b0;

        for (int i = 0; i < 14; i++) begin
            req_valid_i = tbl[i].vld;
            out_ready_i = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(req_ready_o), 32'(tbl[i].rdy));
            @(posedge clk_i);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(out_valid_o), 32'(tbl[i].ov));
            chk($sformatf("v%0d_id", i),    32'(out_id_o),    32'(tbl[i].id));
            chk($sformatf("v%0d_sum", i),   32'(psum()),      32'(tbl[i].sum));
            chk($sformatf("v%0d_cnt", i),   32'(op_count_o),  32'(tbl[i].cnt));
`ifdef MUL_CSV_ARB_FINAL_ADD_EN
            chk($sformatf("v%0d_p", i),     32'(out_p_o),     32'(tbl[i].sum));
`endif
        end

        // Round-robin fairness from reset
        req_valid_i = '0;
        do_reset();
        req_valid_i = 4'b1111;
        out_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("fair_id%0d", k), 32'(out_id_o), 32'(fair_ids[k]));
        end
        chk("fair_cnt", 32'(op_count_o), 32'd6);

        // Backpressure for 5 cycles with result from requester 1 pending
        out_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp_ready%0d", k), 32'(req_ready_o), 32'd0);
            @(posedge clk_i);
            #1;
            chk($sformatf("bp_valid%0d", k), 32'(out_valid_o), 32'd1);
            chk($sformatf("bp_id%0d", k),    32'(out_id_o),    32'd1);
            chk($sformatf("bp_sum%0d", k),   32'(psum()),      32'h0000FFEC);
        end
        chk("bp_cnt", 32'(op_count_o), 32'd6);
        out_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready_o), 32'b0100);
        @(posedge clk_i);
        #1;
        chk("bp_release_id",  32'(out_id_o), 32'd2);
        chk("bp_release_sum", 32'(psum()),   32'h0000FFC4);

        // Asynchronous reset with out_valid=1 and rr_ptr=2
        req_valid_i = '0;
        do_reset();
        req_valid_i = 4'b0010;
        @(posedge clk_i);
        #1;
        chk("pre_rst_valid", 32'(out_valid_o), 32'd1);
        req_valid_i = '0;
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid_o), 32'd0);
        chk("async_rst_cnt",   32'(op_count_o),  32'd0);
        @(posedge clk_i);
        #2 rst_i = 1'b0;
        req_valid_i = 4'b1010;
        #1;
        chk("post_rst_ready", 32'(req_ready_o), 32'b0010);
        @(posedge clk_i);
        #1;
        chk("post_rst_id", 32'(out_id_o), 32'd1);

        // Counter saturation at 4'hF after 20 accepts
        req_valid_i = '0;
        do_reset();
        req_valid_i = 4'b1111;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_i);
            #1;
            if (k == 14) chk("sat_cnt14", 32'(op_count_o), 32'd14);
        end
        chk("sat_cnt20", 32'(op_count_o), 32'hF);

`ifdef MUL_CSV_ARB_FINAL_ADD_EN
        req_valid_i = '0;
        do_reset();
        req_valid_i = 4'b1000;
        @(posedge clk_i);
        #1;
        chk("final_add_p",   32'(out_p_o), 32'h015E);
        chk("final_add_sum", 32'(psum()),  32'h015E);
`endif

        req_valid_i = '0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/mul_csv_sgn_arbiter.md
# mul_csv_sgn_arbiter

Round-robin arbiter and output-register stage that time-shares a single signed carry-save multiplier (`MulCsvSgn`) among `numReq` requesters. Each requester presents a carry-save multiplier (XS, XC) and a multiplicand Y with a valid/ready handshake. The block grants at most one requester per cycle and drives the shared multiplier with that requester's operands. It registers the carry-save product (PS, PC) together with the requester index on a valid/ready output port. It sits between the operand-producing front ends and the downstream carry-save accumulator or final adder.

## Interface
Parameters:
- `numReq`, 4: number of requesters (>= 2).
- `widthX`, 8: width of XS/XC (<= widthY).
- `widthY`, 8: width of Y.
- `speed`, 1: passed unchanged to the multiplier's compressor tree.
- `cntW`, 16: width of the operation counter.

Ports:
- `clk_i`, in, 1: clock. All state changes on the rising edge.
- `rst_i`, in, 1: reset. Asynchronous, active-high.
- `req_valid_i`, in, numReq: request valid, one bit per requester.
- `req_ready_o`, out, numReq: grant/accept, one-hot or zero.
- `req_xs_i`, in, numReq*widthX: packed XS. Requester r uses bits [r*widthX +: widthX].
- `req_xc_i`, in, numReq*widthX: packed XC, same packing as XS.
- `req_y_i`, in, numReq*widthY: packed Y.
- `out_valid_o`, out, 1: result valid.
- `out_ready_i`, in, 1: downstream accepts the result.
- `out_ps_o`, out, widthX+widthY: registered carry-save sum.
- `out_pc_o`, out, widthX+widthY: registered carry-save carry.
- `out_id_o`, out, $clog2(numReq): index of the requester that produced the result.
- `op_count_o`, out, cntW: saturating count of accepted requests.

## Operation
- State: rr_ptr (requester index), output register {valid, ps, pc, id}, op counter.
- Slot free: `slot_free = !out_valid_o || out_ready_i`.
- Arbitration: the grant g is the first r with req_valid_i[r]=1, searching from rr_ptr upward with wrap at numReq. Arbitration is combinational and happens only when slot_free.
- Handshake: `req_ready_o[g] = 1` only when slot_free and some request is valid. All other bits of req_ready_o are 0. req_ready_o never depends on req_ready_o of other requesters.
- Fire (req_valid_i[g] && req_ready_o[g]) at a rising edge:
  - out_valid <= 1.
  - out_ps/out_pc <= shared multiplier output for requester g's operands.
  - out_id <= g.
  - rr_ptr <= (g+1) mod numReq.
  - op counter increments, saturating at 2^cntW-1.
- No fire and out_ready_i=1: out_valid <= 0. Data and id registers hold their values.
- Backpressure (out_valid_o=1, out_ready_i=0): all req_ready_o bits are 0. out_* hold stable, including ps, pc and id.
- Simultaneous output drain and new grant in the same cycle: the new result replaces the old one, and out_valid stays 1. This gives full throughput.
- Multiplier input mux: selects requester g's operands when a grant exists, otherwise requester rr_ptr's operands. Its output is only captured on fire.
- Arithmetic: only out_ps_o + out_pc_o mod 2^(widthX+widthY) is defined, and it equals signed(XS+XC)*signed(Y). Individual PS/PC bit patterns are unspecified. The result is valid only if XS+XC does not overflow widthX signed bits. The arbiter does not check this.
- Requesters must hold their operands stable while valid and not yet granted. A requester may drop valid before being granted; the arbiter then skips it.
- Reset (asynchronous, including mid-transfer): out_valid_o=0, out_ps_o=0, out_pc_o=0, out_id_o=0, rr_ptr=0, op_count_o=0. req_ready_o follows combinationally from the reset state, so the lowest-index valid requester is granted in the first cycle after reset.

## Timing
- Latency: 1 cycle from the accept edge to out_valid_o=1.
- Throughput: 1 result per cycle while out_ready_i=1.
- Critical path: operand mux, then the multiplier tree, then the output register. There is no path from out_ready_i to out_* data.
- Combinational paths: out_ready_i → req_ready_o and req_valid_i → req_ready_o.

## Configuration
- Macro: `MUL_CSV_ARB_FINAL_ADD_EN`.
- Defined: adds output `out_p_o` (widthX+widthY), registered alongside ps/pc and equal to (PS+PC) mod 2^(widthX+widthY). It resets to 0 and follows the same hold and backpressure rules as ps/pc.
- Undefined: the port is absent, and only the carry-save result is produced.

## Test plan
- Signed product: requester 1 only, XS=3, XC=2, Y=8'hFC. Response: one cycle later out_valid_o=1, out_id_o=1, and (out_ps_o+out_pc_o) mod 2^16 = 16'hFFEC (-20).
- Round-robin fairness: all four requesters valid continuously, out_ready_i=1 from reset. Response: out_id_o sequence is 0,1,2,3,0,1 on consecutive cycles, and op_count_o reaches 6.
- Backpressure: result pending, out_ready_i=0 for 5 cycles. Response: req_ready_o=0 throughout and all out_* stable. When out_ready_i rises, the next requester after the last grant is accepted in that same cycle.
- Reset mid-operation: assert rst_i asynchronously while out_valid_o=1 and rr_ptr=2. Response: out_valid_o=0 and op_count_o=0 immediately. After release, with requesters 1 and 3 valid, requester 1 is granted first.
- Counter saturation with cntW=4: perform 20 accepts. Response: op_count_o holds at 4'hF.
- With `MUL_CSV_ARB_FINAL_ADD_EN` defined: XS=8'd100, XC=8'hCE (-50), Y=8'd7. Response: out_p_o=16'h015E (350), equal to out_ps_o+out_pc_o.
